// File: rtl/patch_embed_param_scheduler_pkg.sv
// rtl/patch_embed_param_scheduler_pkg.sv - shared state enum and buffer depth helpers
package patch_embed_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Beats per weight pass: kernel footprint split across the output-channel unroll.
  function automatic int calc_w_depth(input int ky, input int kx, input int ic,
                                      input int uko, input int oc, input int uoc);
    return (ky * kx * ic / uko) * (oc / uoc);
  endfunction

  function automatic int calc_b_depth(input int oc, input int uoc);
    return oc / uoc;
  endfunction

endpackage

// File: rtl/patch_embed_param_scheduler_if.sv
// rtl/patch_embed_param_scheduler_if.sv - load/replay streams and control for the scheduler
interface patch_embed_param_scheduler_if #(
  parameter int W_WIDTH    = 4,
  parameter int BIAS_WIDTH = 4,
  parameter int W_LANES    = 4,
  parameter int B_LANES    = 2
);
  logic [W_LANES-1:0][W_WIDTH-1:0]    weight_in;
  logic                               weight_in_valid;
  logic                               weight_in_ready;
  logic [B_LANES-1:0][BIAS_WIDTH-1:0] bias_in;
  logic                               bias_in_valid;
  logic                               bias_in_ready;
  logic [W_LANES-1:0][W_WIDTH-1:0]    weight;
  logic                               weight_valid;
  logic                               weight_ready;
  logic [B_LANES-1:0][BIAS_WIDTH-1:0] bias;
  logic                               bias_valid;
  logic                               bias_ready;
  logic                               start;
  logic                               flush;
  logic                               loaded;
  logic                               busy;
  logic                               done;

  modport slave (
    input  weight_in, weight_in_valid, bias_in, bias_in_valid,
    input  weight_ready, bias_ready, start, flush,
    output weight_in_ready, bias_in_ready, weight, weight_valid,
    output bias, bias_valid, loaded, busy, done
  );

  modport master (
    output weight_in, weight_in_valid, bias_in, bias_in_valid,
    output weight_ready, bias_ready, start, flush,
    input  weight_in_ready, bias_in_ready, weight, weight_valid,
    input  bias, bias_valid, loaded, busy, done
  );
endinterface

// File: rtl/param_replay_buffer.sv
// rtl/param_replay_buffer.sv - fill-once buffer replayed PASSES times over a valid/ready stream
module param_replay_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 12,
  parameter int PASSES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic              full_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              finished_o
);
  localparam int WC_W = $clog2(DEPTH + 1);
  localparam int RP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(DEPTH);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(DEPTH - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PASSES - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [WC_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [RP_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PC_W-1:0]   pass_q, pass_d;
  logic              active_q, active_d;
  logic              fin_q, fin_d;
  logic              wr_fire, rd_fire;

  assign full_o     = (wr_cnt_q == WC_MAX);
  assign wr_ready_o = load_i && !full_o;
  assign wr_fire    = wr_valid_i && wr_ready_o;
  assign rd_valid_o = active_q;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign rd_fire    = active_q && rd_ready_i;
  assign finished_o = fin_q;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    pass_d   = pass_q;
    active_d = active_q;
    fin_d    = fin_q;
    if (clear_i) begin
      wr_cnt_d = '0;
      rd_ptr_d = '0;
      pass_d   = '0;
      active_d = 1'b0;
      fin_d    = 1'b0;
    end else begin
      if (wr_fire) wr_cnt_d = wr_cnt_q + 1'b1;
      if (start_i) begin
        rd_ptr_d = '0;
        pass_d   = '0;
        active_d = 1'b1;
        fin_d    = 1'b0;
      end else if (rd_fire) begin
        // Wrap to entry 0 at the end of each pass; the last wrap retires the stream.
        if (rd_ptr_q == RP_LAST) begin
          rd_ptr_d = '0;
          if (pass_q == PC_LAST) begin
            active_d = 1'b0;
            fin_d    = 1'b1;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      active_q <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      pass_q   <= pass_d;
      active_q <= active_d;
      fin_q    <= fin_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_cnt_q[RP_W-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/patch_embed_param_scheduler.sv
// rtl/patch_embed_param_scheduler.sv - loads conv weights/bias once, replays them per sliding window
module patch_embed_param_scheduler
  import patch_embed_pkg::*;
#(
  parameter int W_WIDTH           = 4,
  parameter int BIAS_WIDTH        = 4,
  parameter int IN_C              = 3,
  parameter int OUT_C             = 4,
  parameter int KERNEL_Y          = 2,
  parameter int KERNEL_X          = 2,
  parameter int UNROLL_KERNEL_OUT = 2,
  parameter int UNROLL_OUT_C      = 2,
  parameter int SLIDING_NUM       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  patch_embed_param_scheduler_if.slave  bus
);
  localparam int W_DEPTH = calc_w_depth(KERNEL_Y, KERNEL_X, IN_C, UNROLL_KERNEL_OUT,
                                        OUT_C, UNROLL_OUT_C);
  localparam int B_DEPTH = calc_b_depth(OUT_C, UNROLL_OUT_C);
  localparam int W_BITS  = UNROLL_KERNEL_OUT * UNROLL_OUT_C * W_WIDTH;
  localparam int B_BITS  = UNROLL_OUT_C * BIAS_WIDTH;

  state_e            state_q, state_d;
  logic              load_en, run_start, done_c;
  logic              w_full, b_full, w_fin, b_fin;
  logic [W_BITS-1:0] w_rd_data;
  logic [B_BITS-1:0] b_rd_data;

  // Input readies are held low while reset is asserted so every output reads 0 in reset.
  assign load_en = (state_q == ST_LOAD) && !rst;

  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    done_c    = 1'b0;
    if (bus.flush) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  if (w_full && b_full) state_d = ST_READY;
        ST_READY: if (bus.start) begin
          state_d   = ST_RUN;
          run_start = 1'b1;
        end
        ST_RUN:   if (w_fin && b_fin) begin
          state_d = ST_READY;
          done_c  = 1'b1;
        end
        default:  state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  param_replay_buffer #(
    .DATA_W (W_BITS),
    .DEPTH  (W_DEPTH),
    .PASSES (SLIDING_NUM)
  ) u_weight_buf (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (bus.flush),
    .load_i     (load_en),
    .start_i    (run_start),
    .wr_data_i  (bus.weight_in),
    .wr_valid_i (bus.weight_in_valid),
    .wr_ready_o (bus.weight_in_ready),
    .full_o     (w_full),
    .rd_data_o  (w_rd_data),
    .rd_valid_o (bus.weight_valid),
    .rd_ready_i (bus.weight_ready),
    .finished_o (w_fin)
  );

  param_replay_buffer #(
    .DATA_W (B_BITS),
    .DEPTH  (B_DEPTH),
    .PASSES (SLIDING_NUM)
  ) u_bias_buf (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (bus.flush),
    .load_i     (load_en),
    .start_i    (run_start),
    .wr_data_i  (bus.bias_in),
    .wr_valid_i (bus.bias_in_valid),
    .wr_ready_o (bus.bias_in_ready),
    .full_o     (b_full),
    .rd_data_o  (b_rd_data),
    .rd_valid_o (bus.bias_valid),
    .rd_ready_i (bus.bias_ready),
    .finished_o (b_fin)
  );

  assign bus.weight = w_rd_data;
  assign bus.bias   = b_rd_data;
  assign bus.loaded = (state_q != ST_LOAD);
  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = done_c;

endmodule

// File: tb/tb_patch_embed_param_scheduler.sv
// tb/tb_patch_embed_param_scheduler.sv - control vector table plus scoreboarded replay streams
module tb_patch_embed_param_scheduler;
  localparam int W_DEPTH = 12;
  localparam int B_DEPTH = 2;
  localparam int PASSES  = 8;
  localparam int W_LANES = 4;
  localparam int B_LANES = 2;

  typedef logic [W_LANES-1:0][3:0] wbeat_t;
  typedef logic [B_LANES-1:0][3:0] bbeat_t;

  typedef struct {
    string name;
    logic  start;
    logic  flush;
    logic  loaded;
    logic  busy;
    logic  wir;
    logic  bir;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  patch_embed_param_scheduler_if bus ();
  patch_embed_param_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  vec_t   tbl [5];
  wbeat_t w_q [$];
  bbeat_t b_q [$];
  int     total = 0;
  int     bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic wbeat_t wpat(input int k);
    wbeat_t w;
    for (int j = 0; j < W_LANES; j++) w[j] = 4'(k + 4 * j);
    return w;
  endfunction

  function automatic bbeat_t bpat(input int k);
    bbeat_t b;
    for (int j = 0; j < B_LANES; j++) b[j] = 4'(k + 8 * j);
    return b;
  endfunction

  task automatic apply_vec(input int i);
    @(posedge clk); #1;
    bus.start = tbl[i].start;
    bus.flush = tbl[i].flush;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk({tbl[i].name, "_loaded"}, bus.loaded, tbl[i].loaded);
    chk({tbl[i].name, "_busy"}, bus.busy, tbl[i].busy);
    chk({tbl[i].name, "_w_in_ready"}, bus.weight_in_ready, tbl[i].wir);
    chk({tbl[i].name, "_b_in_ready"}, bus.bias_in_ready, tbl[i].bir);
    chk({tbl[i].name, "_valids"}, {bus.weight_valid, bus.bias_valid, bus.done}, 0);
  endtask

  task automatic load_all();
    int wi = 0;
    int bi = 0;
    int cyc = 0;
    while (!(wi == W_DEPTH && bi == B_DEPTH) && cyc < 200) begin
      @(posedge clk); #1;
      bus.weight_in_valid = (wi < W_DEPTH) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.bias_in_valid   = (bi < B_DEPTH) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.weight_in       = wpat(wi);
      bus.bias_in         = bpat(bi);
      @(negedge clk);
      chk("load_w_in_ready", bus.weight_in_ready, wi < W_DEPTH);
      chk("load_b_in_ready", bus.bias_in_ready, bi < B_DEPTH);
      if (bus.weight_in_valid && wi < W_DEPTH) wi++;
      if (bus.bias_in_valid && bi < B_DEPTH) bi++;
      cyc++;
    end
    chk("load_timeout", cyc < 200, 1);
    @(posedge clk); #1;
    bus.weight_in_valid = 1'b0;
    bus.bias_in_valid   = 1'b0;
    @(negedge clk);
    chk("full_readies_low", {bus.weight_in_ready, bus.bias_in_ready}, 0);
    chk("loaded_not_yet", bus.loaded, 0);
    @(negedge clk);
    chk("loaded_set", bus.loaded, 1);
    chk("loaded_not_busy", bus.busy, 0);
  endtask

  task automatic do_start(input bit bp);
    for (int k = 0; k < PASSES * W_DEPTH; k++) w_q.push_back(wpat(k % W_DEPTH));
    for (int k = 0; k < PASSES * B_DEPTH; k++) b_q.push_back(bpat(k % B_DEPTH));
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(negedge clk);
    chk("pre_start_valid", {bus.weight_valid, bus.bias_valid}, 0);
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.weight_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.bias_ready   = 1'b1;
  endtask

  task automatic run_stream(input bit bp, input int stop_w, output int n_w, output int n_b,
                            output int n_done, output int w_last, output int b_last);
    wbeat_t held = '0;
    bit     stalled = 1'b0;
    bit     first = 1'b1;
    int     cyc = 0;
    n_w = 0; n_b = 0; n_done = 0; w_last = 0; b_last = 0;
    forever begin
      @(negedge clk);
      if (first) begin
        chk("start_latency", {bus.weight_valid, bus.bias_valid, bus.busy}, 3'b111);
        first = 1'b0;
      end
      if (bus.done) begin
        n_done++;
        chk("done_after_last", (w_q.size() == 0) && (b_q.size() == 0), 1);
      end
      if (stalled) chk("w_stable", {bus.weight_valid, bus.weight}, {1'b1, held});
      stalled = bus.weight_valid && !bus.weight_ready;
      held    = bus.weight;
      if (bus.weight_valid && bus.weight_ready) begin
        chk("w_expected", w_q.size() != 0, 1);
        if (w_q.size() != 0) chk("w_data", bus.weight, w_q.pop_front());
        n_w++;
        w_last = cyc;
      end
      if (bus.bias_valid && bus.bias_ready) begin
        chk("b_expected", b_q.size() != 0, 1);
        if (b_q.size() != 0) chk("b_data", bus.bias, b_q.pop_front());
        n_b++;
        b_last = cyc;
      end
      if (!bus.busy || (stop_w != 0 && n_w == stop_w) || cyc == 3000) break;
      @(posedge clk); #1;
      bus.weight_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc++;
    end
    if (stop_w == 0) chk("run_timeout", bus.busy, 0);
  endtask

  task automatic check_full_run(input string tag, input int n_w, input int n_b, input int n_done);
    chk({tag, "_w_beats"}, n_w, PASSES * W_DEPTH);
    chk({tag, "_b_beats"}, n_b, PASSES * B_DEPTH);
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_after"}, {bus.busy, bus.loaded, bus.weight_valid, bus.bias_valid}, 4'b0100);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_w, n_b, n_done, w_last, b_last;
    tbl[0] = '{"load_idle",          1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{"load_start_ignored", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{"load_flush",         1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{"ready_idle",         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{"flush_beats_start",  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    bus.weight_in = '0; bus.weight_in_valid = 1'b0;
    bus.bias_in = '0;   bus.bias_in_valid = 1'b0;
    bus.weight_ready = 1'b0; bus.bias_ready = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0;

    @(negedge clk);
    chk("reset_outputs", {bus.weight_valid, bus.bias_valid, bus.busy, bus.loaded, bus.done,
                          bus.weight_in_ready, bus.bias_in_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 3; i++) apply_vec(i);
    load_all();
    apply_vec(3);
    apply_vec(4);
    load_all();
    apply_vec(3);

    do_start(1'b0);
    run_stream(1'b0, 0, n_w, n_b, n_done, w_last, b_last);
    check_full_run("run_tied", n_w, n_b, n_done);

    do_start(1'b1);
    run_stream(1'b1, 0, n_w, n_b, n_done, w_last, b_last);
    check_full_run("run_bp", n_w, n_b, n_done);
    chk("bias_finishes_early", b_last < w_last, 1);

    do_start(1'b0);
    run_stream(1'b0, 40, n_w, n_b, n_done, w_last, b_last);
    chk("flush_point", n_w, 40);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_no_done", bus.done, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("after_flush", {bus.weight_valid, bus.bias_valid, bus.busy, bus.loaded, bus.done}, 0);
    chk("after_flush_readies", {bus.weight_in_ready, bus.bias_in_ready}, 2'b11);
    chk("flush_no_done_seen", n_done, 0);
    w_q.delete();
    b_q.delete();

    load_all();
    do_start(1'b0);
    run_stream(1'b0, 20, n_w, n_b, n_done, w_last, b_last);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {bus.weight_valid, bus.bias_valid, bus.busy, bus.loaded, bus.done,
                                bus.weight_in_ready, bus.bias_in_ready}, 0);
    w_q.delete();
    b_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_after_reset_ignored", {bus.busy, bus.loaded, bus.weight_valid, bus.bias_valid}, 0);

    load_all();
    do_start(1'b0);
    run_stream(1'b0, 0, n_w, n_b, n_done, w_last, b_last);
    check_full_run("run_reload", n_w, n_b, n_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
